// File: rtl/ransac_point_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ransac_point_fetch                                                       |
// | Streams signed (x,y) point words from data memory to the scoring path.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ransac_point_fetch #(
    parameter int ADDR_W     = 14,
    parameter int CNT_W      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               csr_address,
    input  logic                     csr_write,
    input  logic [31:0]              csr_writedata,
    input  logic                     csr_read,
    output logic [31:0]              csr_readdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_chipselect,
    output logic                     mem_write,
    output logic [3:0]               mem_byteenable,
    output logic                     mem_clken,
    input  logic [31:0]              mem_readdata,
    output logic signed [15:0]       pt_x,
    output logic signed [15:0]       pt_y,
    output logic [CNT_W-1:0]         pt_index,
    output logic                     pt_last,
    output logic                     pt_valid,
    input  logic                     pt_ready,
    output logic                     irq
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W:0] C_DEPTH = (FCNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    emitted_q, emitted_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    rd_left_q, rd_left_d;
    logic                inflight_q, inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [31:0]         fifo_mem [FIFO_DEPTH];

    logic        ctrl_wr, start_req, abort_req, busy, start_ok, abort_ok;
    logic        credit, issue, push, pop;
    logic [31:0] head;
    logic        unused_inputs;

    assign unused_inputs = ^{csr_read, csr_writedata};

    assign ctrl_wr   = csr_write && (csr_address == 2'd0);
    assign start_req = ctrl_wr && csr_writedata[0];
    assign abort_req = ctrl_wr && csr_writedata[1];
    assign busy      = (state_q != IDLE);
    assign start_ok  = start_req && !abort_req && !busy;
    assign abort_ok  = abort_req && busy;

    // Outstanding reads (buffered + in flight) never exceed the buffer size,
    // so a returning word always has a free slot.
    assign credit = ({1'b0, fcnt_q} + (FCNT_W + 1)'(inflight_q)) < C_DEPTH;
    assign issue  = (state_q == FETCH) && !abort_ok && (rd_left_q != '0) && credit;
    assign push   = inflight_q && !abort_ok;
    assign pop    = pt_valid && pt_ready;

    assign mem_address    = rd_addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign head     = fifo_mem[rd_ptr_q];
    assign pt_valid = (fcnt_q != '0);
    assign pt_x     = pt_valid ? head[31:16] : '0;
    assign pt_y     = pt_valid ? head[15:0]  : '0;
    assign pt_index = emitted_q;
    assign pt_last  = pt_valid && (emitted_q == count_q - CNT_W'(1));
    assign irq      = done_q && irq_en_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        emitted_d  = emitted_q;
        rd_addr_d  = rd_addr_q;
        rd_left_d  = rd_left_q;
        inflight_d = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;

        if (csr_write && !busy) begin
            if (csr_address == 2'd1) base_d  = csr_writedata[ADDR_W-1:0];
            if (csr_address == 2'd2) count_d = csr_writedata[CNT_W-1:0];
        end
        if (ctrl_wr) irq_en_d = csr_writedata[2];

        if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_left_d = rd_left_q - CNT_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            emitted_d = emitted_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    done_d    = 1'b0;
                    emitted_d = '0;
                    rd_addr_d = base_q;
                    rd_left_d = count_q;
                    if (count_q == '0) done_d = 1'b1;
                    else               state_d = FETCH;
                end
            end
            FETCH: begin
                if (abort_ok)                                state_d = IDLE;
                else if (issue && rd_left_q == CNT_W'(1))    state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_ok) begin
                    state_d = IDLE;
                end else if (!inflight_q && fcnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops buffered words and the read still in flight.
        if (abort_ok) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fcnt_d     = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            emitted_q  <= '0;
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            emitted_q  <= emitted_d;
            rd_addr_q  <= rd_addr_d;
            rd_left_q  <= rd_left_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_readdata;
    end

    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            2'd0: csr_readdata[2]              = irq_en_q;
            2'd1: csr_readdata[ADDR_W-1:0]     = base_q;
            2'd2: csr_readdata[CNT_W-1:0]      = count_q;
            default: begin
                csr_readdata[0]                = busy;
                csr_readdata[1]                = done_q;
                csr_readdata[16 +: CNT_W]      = emitted_q;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ransac_point_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ransac_point_fetch                                                    |
// | Directed self-checking bench for ransac_point_fetch.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ransac_point_fetch;
    localparam int ADDR_W     = 14;
    localparam int CNT_W      = 15;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [CNT_W-1:0]   idx;
        logic               last;
    } pt_t;

    logic               clk;
    logic               reset;
    logic [1:0]         csr_address;
    logic               csr_write;
    logic [31:0]        csr_writedata;
    logic               csr_read;
    logic [31:0]        csr_readdata;
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_chipselect;
    logic               mem_write;
    logic [3:0]         mem_byteenable;
    logic               mem_clken;
    logic [31:0]        mem_readdata;
    logic signed [15:0] pt_x;
    logic signed [15:0] pt_y;
    logic [CNT_W-1:0]   pt_index;
    logic               pt_last;
    logic               pt_valid;
    logic               pt_ready;
    logic               irq;

    ransac_point_fetch #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_read       (csr_read),
        .csr_readdata   (csr_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pt_x           (pt_x),
        .pt_y           (pt_y),
        .pt_index       (pt_index),
        .pt_last        (pt_last),
        .pt_valid       (pt_valid),
        .pt_ready       (pt_ready),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stream / memory-port monitor
    logic [ADDR_W-1:0] issq[$];
    pt_t               rxq[$];
    int                iss_cnt = 0;
    int                xfer_cnt = 0;
    int                occ_viol = 0;
    int                valid_rise_cyc = -1;
    bit                hold_en = 1'b1;
    logic              prev_valid = 1'b0;
    logic              prev_stall = 1'b0;
    logic [31:0]       prev_xy = '0;
    logic [31:0]       prev_il = '0;
    int                wr_cyc = 0;

    always @(negedge clk) begin
        pt_t p;
        if (!reset) begin
            if (mem_chipselect) begin
                if (iss_cnt - xfer_cnt >= FIFO_DEPTH) occ_viol++;
                issq.push_back(mem_address);
                iss_cnt++;
            end
            if (pt_valid && !prev_valid) valid_rise_cyc = cyc;
            if (hold_en && prev_stall) begin
                check("hold_valid", pt_valid, 1);
                check("hold_xy", {pt_x, pt_y}, prev_xy);
                check("hold_idx_last", {pt_last, pt_index}, prev_il);
            end
            if (pt_valid && pt_ready) begin
                p.x = pt_x; p.y = pt_y; p.idx = pt_index; p.last = pt_last;
                rxq.push_back(p);
                xfer_cnt++;
            end
            if (csr_write && csr_address == 2'd0 && csr_writedata[1]) iss_cnt = xfer_cnt;
        end
        prev_valid = pt_valid;
        prev_stall = pt_valid && !pt_ready;
        prev_xy    = {pt_x, pt_y};
        prev_il    = 32'({pt_last, pt_index});
    end

    function automatic pt_t rx_at(input int k);
        pt_t p;
        p.x = '0; p.y = '0; p.idx = '0; p.last = 1'b0;
        if (k < rxq.size()) p = rxq[k];
        return p;
    endfunction

    function automatic logic [ADDR_W-1:0] iss_at(input int k);
        logic [ADDR_W-1:0] a;
        a = '1;
        if (k < issq.size()) a = issq[k];
        return a;
    endfunction

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_writedata = d; csr_write = 1'b1; wr_cyc = cyc;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        #1 d = csr_readdata;
        csr_read = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(posedge clk); #1;
            csr_rd(2'd3, d);
            if (d[1]) begin ok = 1'b1; break; end
        end
        if (!ok) check(tag, 0, 1);
    endtask

    // Compares a finished run against the bench memory image.
    task automatic check_run(input string tag, input int s_rx, input int s_iss,
                             input int n, input int base_a);
        pt_t p;
        logic [ADDR_W-1:0] a;
        check({tag, "_npts"}, rxq.size() - s_rx, n);
        check({tag, "_niss"}, issq.size() - s_iss, n);
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(base_a + i);
            p = rx_at(s_rx + i);
            check({tag, "_addr"}, iss_at(s_iss + i), a);
            check({tag, "_xy"}, {p.x, p.y}, mem[a]);
            check({tag, "_idx"}, p.idx, i);
            check({tag, "_last"}, p.last, (i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          s_rx, s_iss, t0, v0;
        pt_t         p;
        int          t1x[4];
        int          t1y[4];
        logic [3:0]  rpat;
        bit          ok;

        t1x = '{1, 2, -32768, 0};
        t1y = '{-1, 3, 32767, 0};
        rpat = 4'b1001;

        reset = 1'b1; csr_address = '0; csr_write = 1'b0; csr_writedata = '0;
        csr_read = 1'b0; pt_ready = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 'h100; i < 'h400; i++) mem[i] = {16'(i ^ 'h0F0F), 16'(i * 7)};
        mem['h10] = 32'h0001FFFF; mem['h11] = 32'h00020003;
        mem['h12] = 32'h80007FFF; mem['h13] = 32'h00000000;
        mem['h3FFE] = 32'h00050006; mem['h3FFF] = 32'h0007FFF8;
        mem['h0000] = 32'hFFFF0000; mem['h0001] = 32'h12348001;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_valid", pt_valid, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_xy", {pt_x, pt_y}, 0);
        check("rst_idx_last", {pt_last, pt_index}, 0);
        check("rst_irq", irq, 0);
        csr_rd(2'd3, d); check("rst_status", d, 0);
        csr_rd(2'd0, d); check("rst_ctrl", d, 0);
        csr_rd(2'd1, d); check("rst_base", d, 0);
        csr_rd(2'd2, d); check("rst_count", d, 0);
        reset = 1'b0;

        // Test 1: basic run with sign extremes and latency
        csr_wr(2'd1, 32'h10);
        csr_wr(2'd2, 4);
        s_rx = rxq.size(); s_iss = issq.size();
        csr_wr(2'd0, 1);
        t0 = wr_cyc;
        check("t1_cs_first", mem_chipselect, 1);
        check("t1_addr_first", mem_address, 'h10);
        wait_done(50, "t1_timeout");
        check("t1_first_valid_cyc", valid_rise_cyc, t0 + 3);
        check("t1_npts", rxq.size() - s_rx, 4);
        for (int i = 0; i < 4; i++) begin
            p = rx_at(s_rx + i);
            check("t1_x", int'(p.x), t1x[i]);
            check("t1_y", int'(p.y), t1y[i]);
            check("t1_idx", p.idx, i);
            check("t1_last", p.last, (i == 3));
            check("t1_addr", iss_at(s_iss + i), 'h10 + i);
        end
        csr_rd(2'd3, d); check("t1_status", d, 32'h00040002);
        check("t1_irq", irq, 0);

        // Test 2: address wrap
        csr_wr(2'd1, 32'h3FFE);
        s_rx = rxq.size(); s_iss = issq.size();
        csr_wr(2'd0, 1);
        wait_done(50, "t2_timeout");
        check_run("t2", s_rx, s_iss, 4, 'h3FFE);

        // Test 3: backpressure 1,0,0,1
        csr_wr(2'd1, 32'h100);
        csr_wr(2'd2, 10);
        s_rx = rxq.size(); s_iss = issq.size(); v0 = occ_viol;
        csr_wr(2'd0, 1);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            pt_ready = rpat[c % 4];
            csr_rd(2'd3, d);
            if (d[1]) begin ok = 1'b1; break; end
        end
        if (!ok) check("t3_timeout", 0, 1);
        pt_ready = 1'b1;
        check_run("t3", s_rx, s_iss, 10, 'h100);
        check("t3_outstanding", occ_viol - v0, 0);
        csr_rd(2'd3, d); check("t3_status", d, 32'h000A0002);

        // Test 4: zero count with interrupt enabled
        check("t4_irq_before", irq, 0);
        csr_wr(2'd2, 0);
        s_iss = issq.size();
        csr_wr(2'd0, 32'h5);
        csr_rd(2'd3, d); check("t4_status", d, 32'h00000002);
        check("t4_irq", irq, 1);
        csr_rd(2'd0, d); check("t4_ctrl", d, 32'h4);
        repeat (3) @(posedge clk); #1;
        check("t4_no_issue", issq.size() - s_iss, 0);

        // Test 5: abort with the stream stalled
        hold_en = 1'b0;
        pt_ready = 1'b0;
        csr_wr(2'd1, 32'h200);
        csr_wr(2'd2, 8);
        s_iss = issq.size();
        csr_wr(2'd0, 1);
        check("t5_irq_off", irq, 0);
        repeat (2) @(posedge clk); #1;
        check("t5_valid_pre", pt_valid, 1);
        csr_wr(2'd0, 32'h2);
        check("t5_valid_post", pt_valid, 0);
        csr_rd(2'd3, d); check("t5_status", d, 32'h00000000);
        repeat (4) @(posedge clk); #1;
        check("t5_niss", issq.size() - s_iss, 3);
        check("t5_valid_idle", pt_valid, 0);
        pt_ready = 1'b1;
        hold_en = 1'b1;
        csr_wr(2'd1, 32'h300);
        csr_wr(2'd2, 2);
        s_rx = rxq.size(); s_iss = issq.size();
        csr_wr(2'd0, 1);
        wait_done(50, "t5b_timeout");
        check_run("t5b", s_rx, s_iss, 2, 'h300);

        // Test 6: register writes and restart while busy
        pt_ready = 1'b0;
        csr_wr(2'd1, 32'h380);
        csr_wr(2'd2, 6);
        s_rx = rxq.size(); s_iss = issq.size();
        csr_wr(2'd0, 1);
        csr_wr(2'd1, 32'h555);
        csr_wr(2'd2, 1);
        csr_wr(2'd0, 1);
        csr_rd(2'd1, d); check("t6_base", d, 32'h380);
        csr_rd(2'd2, d); check("t6_count", d, 6);
        csr_rd(2'd3, d); check("t6_busy", d[1:0], 2'b01);
        pt_ready = 1'b1;
        wait_done(50, "t6_timeout");
        check_run("t6", s_rx, s_iss, 6, 'h380);
        csr_rd(2'd3, d); check("t6_status", d, 32'h00060002);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
